// File: rtl/lcd_status_display.sv
// HD44780 status writer: paints labelled stat digits on row 0 and a face code on row 1,
// then rewrites only the fields whose clamped value differs from what is on the glass.
module lcd_status_display #(
  parameter int          NUM_CHANNELS = 3,
  parameter int          MAX_VALUE    = 5,
  parameter int          NUM_FACES    = 9,
  parameter logic [31:0] LABELS       = "FJEX",
  parameter int          COUNT_MAX    = 8,
  parameter int          INIT_WAIT    = 16,
  localparam int         VW           = $clog2(MAX_VALUE + 1),
  localparam int         FW           = $clog2(NUM_FACES)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [FW-1:0]              face,
  input  logic [NUM_CHANNELS*VW-1:0] values,
  input  logic                       force_refresh,
  output logic                       rs,
  output logic                       rw,
  output logic                       enable,
  output logic [7:0]                 data,
  output logic                       busy,
  output logic                       ready
);

  localparam int TMAX = (INIT_WAIT > COUNT_MAX) ? INIT_WAIT : COUNT_MAX;
  localparam int CW   = $clog2(TMAX + 1);
  localparam logic [4:0]    FULL_LAST  = 5'(3 + 4 * NUM_CHANNELS - 1);
  localparam logic [4:0]    CHAN_LAST  = 5'(4 * NUM_CHANNELS);
  localparam logic [4:0]    FACE_ADDR  = 5'(4 * NUM_CHANNELS + 1);
  localparam logic [VW-1:0] MAX_V      = VW'(MAX_VALUE);
  localparam logic [FW-1:0] MAX_F      = FW'(NUM_FACES - 1);
  localparam logic [CW-1:0] PH_LAST    = CW'(COUNT_MAX - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(INIT_WAIT - 1);

  typedef enum logic [2:0] {
    S_WAIT_POWER,
    S_INIT,
    S_FULL,
    S_IDLE,
    S_FIELD_ADDR,
    S_FIELD_DATA
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      ph_q, ph_d;
  logic [4:0]      idx_q, idx_d;
  logic [1:0]      chan_q, chan_d;
  logic            face_sel_q, face_sel_d;
  logic            pend_q, pend_d;
  logic            ready_q, ready_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            enable_q, enable_d;
  logic [VW-1:0]   shadow_q [4];
  logic [FW-1:0]   face_shadow_q;

  logic [VW-1:0]   clamp_v [4];
  logic [7:0]      digit_char [4];
  logic [7:0]      label_char [4];
  logic [3:0]      diff;
  logic [FW-1:0]   clamp_f;
  logic [7:0]      face_char;
  logic            face_diff;
  logic            dirty_any;
  logic [1:0]      dirty_sel;

  logic            in_byte, byte_done;
  logic [4:0]      full_idx;
  logic [3:0]      full_k;
  logic            full_rs;
  logic [7:0]      full_data;
  logic [3:0]      full_ld_ch;
  logic            full_ld_face;
  logic [1:0]      init_idx;
  logic [7:0]      init_cmd;

  logic            issue, issue_rs, enter_full, ld_face;
  logic [7:0]      issue_data;
  logic [3:0]      ld_ch;

  // Unused channel slots clamp to zero and never get loaded, so they never look dirty.
  for (genvar gi = 0; gi < 4; gi++) begin : g_chan
    if (gi < NUM_CHANNELS) begin : g_used
      logic [VW-1:0] raw;
      assign raw         = values[gi*VW +: VW];
      assign clamp_v[gi] = (raw > MAX_V) ? MAX_V : raw;
    end else begin : g_unused
      assign clamp_v[gi] = '0;
    end
    assign digit_char[gi] = 8'h30 + 8'(clamp_v[gi]);
    assign label_char[gi] = LABELS[8*(3-gi) +: 8];
    assign diff[gi]       = (clamp_v[gi] != shadow_q[gi]);
  end

  assign clamp_f   = (face > MAX_F) ? MAX_F : face;
  assign face_char = 8'h30 + 8'(clamp_f);
  assign face_diff = (clamp_f != face_shadow_q);

  always_comb begin
    dirty_any = |diff;
    dirty_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (diff[i]) dirty_sel = 2'(i);
    end
  end

  assign in_byte   = (state_q == S_INIT) || (state_q == S_FULL) ||
                     (state_q == S_FIELD_ADDR) || (state_q == S_FIELD_DATA);
  assign byte_done = (ph_q == 2'd2) && (cnt_q == PH_LAST);

  // Byte to issue next in the full paint; index 0 whenever FULL is being entered.
  always_comb begin
    full_idx     = (state_q == S_FULL) ? idx_q + 5'd1 : 5'd0;
    full_k       = 4'(full_idx - 5'd1);
    full_rs      = 1'b1;
    full_data    = 8'h20;
    full_ld_ch   = '0;
    full_ld_face = 1'b0;
    if (full_idx == 5'd0) begin
      full_rs   = 1'b0;
      full_data = 8'h80;
    end else if (full_idx <= CHAN_LAST) begin
      case (full_k[1:0])
        2'd0: full_data = label_char[full_k[3:2]];
        2'd1: full_data = 8'h3A;
        2'd2: begin
          full_data                = digit_char[full_k[3:2]];
          full_ld_ch[full_k[3:2]]  = 1'b1;
        end
        default: full_data = 8'h20;
      endcase
    end else if (full_idx == FACE_ADDR) begin
      full_rs   = 1'b0;
      full_data = 8'hC0;
    end else begin
      full_data    = face_char;
      full_ld_face = 1'b1;
    end
  end

  always_comb begin
    init_idx = (state_q == S_INIT) ? idx_q[1:0] + 2'd1 : 2'd0;
    case (init_idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ph_d       = ph_q;
    idx_d      = idx_q;
    chan_d     = chan_q;
    face_sel_d = face_sel_q;
    ready_d    = ready_q;
    rs_d       = rs_q;
    data_d     = data_q;
    enable_d   = 1'b0;
    issue      = 1'b0;
    issue_rs   = 1'b0;
    issue_data = 8'h00;
    ld_ch      = '0;
    ld_face    = 1'b0;
    enter_full = 1'b0;

    if (in_byte && !byte_done) begin
      if (cnt_q == PH_LAST) begin
        cnt_d = '0;
        ph_d  = ph_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      enable_d = (ph_d == 2'd1);
    end

    case (state_q)
      S_WAIT_POWER: begin
        if (cnt_q == WAIT_LAST) begin
          state_d    = S_INIT;
          idx_d      = 5'd0;
          issue      = 1'b1;
          issue_data = init_cmd;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_INIT: begin
        if (byte_done) begin
          issue = 1'b1;
          if (idx_q == 5'd3) begin
            state_d    = S_FULL;
            idx_d      = 5'd0;
            enter_full = 1'b1;
            issue_rs   = full_rs;
            issue_data = full_data;
          end else begin
            idx_d      = idx_q + 5'd1;
            issue_data = init_cmd;
          end
        end
      end
      S_FULL: begin
        if (byte_done) begin
          if (idx_q == FULL_LAST) begin
            state_d = S_IDLE;
            ready_d = 1'b1;
          end else begin
            idx_d      = full_idx;
            issue      = 1'b1;
            issue_rs   = full_rs;
            issue_data = full_data;
            ld_ch      = full_ld_ch;
            ld_face    = full_ld_face;
          end
        end
      end
      S_IDLE: begin
        if (pend_q) begin
          state_d    = S_FULL;
          idx_d      = 5'd0;
          enter_full = 1'b1;
          issue      = 1'b1;
          issue_rs   = full_rs;
          issue_data = full_data;
        end else if (dirty_any) begin
          state_d    = S_FIELD_ADDR;
          chan_d     = dirty_sel;
          face_sel_d = 1'b0;
          issue      = 1'b1;
          issue_data = 8'h82 + 8'({dirty_sel, 2'b00});
        end else if (face_diff) begin
          state_d    = S_FIELD_ADDR;
          face_sel_d = 1'b1;
          issue      = 1'b1;
          issue_data = 8'hC0;
        end
      end
      S_FIELD_ADDR: begin
        if (byte_done) begin
          state_d  = S_FIELD_DATA;
          issue    = 1'b1;
          issue_rs = 1'b1;
          if (face_sel_q) begin
            issue_data = face_char;
            ld_face    = 1'b1;
          end else begin
            issue_data    = digit_char[chan_q];
            ld_ch[chan_q] = 1'b1;
          end
        end
      end
      S_FIELD_DATA: begin
        if (byte_done) state_d = S_IDLE;
      end
      default: state_d = S_WAIT_POWER;
    endcase

    // A newly issued byte always starts in SETUP with the strobe low.
    if (issue) begin
      rs_d     = issue_rs;
      data_d   = issue_data;
      cnt_d    = '0;
      ph_d     = 2'd0;
      enable_d = 1'b0;
    end
  end

  assign pend_d = force_refresh | (pend_q & ~enter_full);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_WAIT_POWER;
      cnt_q         <= '0;
      ph_q          <= 2'd0;
      idx_q         <= 5'd0;
      chan_q        <= 2'd0;
      face_sel_q    <= 1'b0;
      pend_q        <= 1'b0;
      ready_q       <= 1'b0;
      rs_q          <= 1'b0;
      data_q        <= 8'h00;
      enable_q      <= 1'b0;
      face_shadow_q <= '0;
      for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ph_q       <= ph_d;
      idx_q      <= idx_d;
      chan_q     <= chan_d;
      face_sel_q <= face_sel_d;
      pend_q     <= pend_d;
      ready_q    <= ready_d;
      rs_q       <= rs_d;
      data_q     <= data_d;
      enable_q   <= enable_d;
      if (ld_face) face_shadow_q <= clamp_f;
      for (int i = 0; i < 4; i++) begin
        if (ld_ch[i]) shadow_q[i] <= clamp_v[i];
      end
    end
  end

  assign rs     = rs_q;
  assign rw     = 1'b0;
  assign enable = enable_q;
  assign data   = data_q;
  assign busy   = (state_q != S_IDLE);
  assign ready  = ready_q;

endmodule

// File: tb/tb_lcd_status_display.sv
// Scoreboard bench: stimulus queues the bus bytes the panel should receive, a monitor
// pops one per enable pulse and checks it together with the strobe timing.
module tb_lcd_status_display;

  localparam int NCH  = 3;
  localparam int MAXV = 5;
  localparam int NF   = 9;
  localparam int CM   = 8;
  localparam int IW   = 16;
  localparam int VW   = 3;
  localparam int FW   = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              force_refresh = 1'b0;
  logic [FW-1:0]     face = '0;
  logic [NCH*VW-1:0] values = '0;
  logic              rs, rw, enable, busy, ready;
  logic [7:0]        data;

  lcd_status_display #(
    .NUM_CHANNELS(NCH), .MAX_VALUE(MAXV), .NUM_FACES(NF),
    .LABELS("FJEX"), .COUNT_MAX(CM), .INIT_WAIT(IW)
  ) dut (
    .clk(clk), .reset(reset), .face(face), .values(values),
    .force_refresh(force_refresh), .rs(rs), .rw(rw), .enable(enable),
    .data(data), .busy(busy), .ready(ready)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_fail = 0;
  logic [8:0] exp_q[$];
  int         cur_val[NCH];
  int         cur_face;
  int         sh[NCH];
  int         sh_face;
  logic [7:0] lbl[4] = '{8'h46, 8'h4A, 8'h45, 8'h58};
  int         busy_falls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic int clampv(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  function automatic int clampf(input int f);
    return (f > NF - 1) ? NF - 1 : f;
  endfunction

  task automatic push(input logic r, input logic [7:0] d);
    exp_q.push_back({r, d});
  endtask

  task automatic drive();
    for (int i = 0; i < NCH; i++) values[i*VW +: VW] = VW'(cur_val[i]);
    face = FW'(cur_face);
  endtask

  task automatic push_full();
    push(1'b0, 8'h80);
    for (int i = 0; i < NCH; i++) begin
      push(1'b1, lbl[i]);
      push(1'b1, 8'h3A);
      push(1'b1, 8'h30 + 8'(clampv(cur_val[i])));
      push(1'b1, 8'h20);
      sh[i] = clampv(cur_val[i]);
    end
    push(1'b0, 8'hC0);
    push(1'b1, 8'h30 + 8'(clampf(cur_face)));
    sh_face = clampf(cur_face);
  endtask

  task automatic push_init();
    push(1'b0, 8'h38);
    push(1'b0, 8'h0C);
    push(1'b0, 8'h01);
    push(1'b0, 8'h06);
    push_full();
  endtask

  task automatic push_delta();
    for (int i = 0; i < NCH; i++) begin
      if (clampv(cur_val[i]) != sh[i]) begin
        push(1'b0, 8'h80 + 8'(4 * i + 2));
        push(1'b1, 8'h30 + 8'(clampv(cur_val[i])));
        sh[i] = clampv(cur_val[i]);
      end
    end
    if (clampf(cur_face) != sh_face) begin
      push(1'b0, 8'hC0);
      push(1'b1, 8'h30 + 8'(clampf(cur_face)));
      sh_face = clampf(cur_face);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && !busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", 32'(n < budget), 1);
  endtask

  task automatic measure_ready(input string name);
    int n;
    n = 0;
    while (n < 5000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ready) break;
    end
    check(name, n, IW + 19 * 3 * CM);
    check("busy_at_ready", 32'(busy), 0);
  endtask

  // Monitor: one expected byte per rising strobe; width and bus stability at the fall.
  initial begin
    logic       en_prev;
    int         width;
    logic [8:0] cap;
    logic [8:0] e;
    en_prev = 1'b0;
    width   = 0;
    cap     = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        en_prev = 1'b0;
        width   = 0;
      end else begin
        if (enable && !en_prev) begin
          cap   = {rs, data};
          width = 0;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_byte: got rs=%0d data=%02h, expected no byte", rs, data);
          end else begin
            e = exp_q.pop_front();
            check("bus_byte", 32'(cap), 32'(e));
          end
        end
        if (enable) width++;
        if (!enable && en_prev) begin
          check("pulse_width", width, CM);
          check("bus_hold", 32'({rs, data}), 32'(cap));
          check("rw_low", 32'(rw), 0);
        end
        en_prev = enable;
      end
    end
  end

  initial begin
    logic busy_prev;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_prev && !busy) busy_falls++;
      busy_prev = busy;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected summary before time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int hi;
    int guard;
    logic do_force;

    for (int i = 0; i < NCH; i++) cur_val[i] = 5;
    cur_face = 0;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rs", 32'(rs), 0);
    check("rst_rw", 32'(rw), 0);
    check("rst_enable", 32'(enable), 0);
    check("rst_data", 32'(data), 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_ready", 32'(ready), 0);

    for (int i = 0; i < NCH; i++) sh[i] = 0;
    sh_face = 0;
    push_init();
    @(posedge clk);
    #1 reset = 1'b0;
    measure_ready("powerup_ready_latency");
    wait_idle(200);

    // single field change and its busy duration
    step();
    cur_val[0] = 0;
    drive();
    push_delta();
    hi = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (busy) hi++;
      else if (hi > 0) break;
    end
    check("update_busy_cycles", hi, 2 * 3 * CM);
    wait_idle(200);

    // channel and face change together: two separate field writes
    step();
    busy_falls = 0;
    cur_val[2] = 2;
    cur_face   = 3;
    drive();
    push_delta();
    wait_idle(500);
    check("busy_falls_between_fields", busy_falls, 2);

    // out-of-range value is clamped and then stays quiet
    step();
    cur_val[0] = 7;
    drive();
    push_delta();
    wait_idle(300);
    repeat (100) @(negedge clk);
    check("clamp_hold_busy", 32'(busy), 0);
    check("clamp_hold_queue", exp_q.size(), 0);

    // two force pulses during a field write merge into one repaint
    step();
    cur_val[0] = 3;
    drive();
    push_delta();
    repeat (12) @(posedge clk);
    #1;
    check("busy_at_force", 32'(busy), 1);
    force_refresh = 1'b1;
    step();
    force_refresh = 1'b0;
    repeat (5) @(posedge clk);
    #1 force_refresh = 1'b1;
    step();
    force_refresh = 1'b0;
    push_full();
    wait_idle(1500);
    repeat (40) @(negedge clk);
    check("single_repaint_busy", 32'(busy), 0);
    check("single_repaint_queue", exp_q.size(), 0);

    // reset in the middle of an enable pulse
    step();
    cur_val[2] = 4;
    drive();
    push_delta();
    guard = 0;
    while (!enable && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("enable_seen", 32'(enable), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midpulse_enable", 32'(enable), 0);
    check("midpulse_busy", 32'(busy), 1);
    check("midpulse_ready", 32'(ready), 0);
    check("midpulse_data", 32'(data), 0);
    exp_q.delete();
    for (int i = 0; i < NCH; i++) sh[i] = 0;
    sh_face = 0;
    push_init();
    @(posedge clk);
    #1 reset = 1'b0;
    measure_ready("reinit_ready_latency");
    wait_idle(200);

    // randomized updates, some preceded by a force pulse
    for (int it = 0; it < 24; it++) begin
      do_force = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 2) == 0) cur_val[i] = int'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 2) == 0) cur_face = int'($urandom_range(0, 15));
      step();
      if (do_force) begin
        force_refresh = 1'b1;
        step();
        force_refresh = 1'b0;
        drive();
        push_full();
      end else begin
        drive();
        push_delta();
      end
      wait_idle(1500);
      check("rand_ready", 32'(ready), 1);
    end

    repeat (40) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
